// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the RV32 PC / instruction-fetch sequencer.
package pc_seq_pkg;

    localparam int unsigned PC_STEP    = 4;
    localparam int unsigned ALIGN_MASK = 3;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_JMP = 2'd2
    } next_sel_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bundle: redirect inputs, imem handshake and decode-facing PC outputs.
interface pc_fetch_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] pc_plus4;
    logic              misalign_err;

    modport master (
        input  stall, branch_taken, branch_target, jump, jump_target, imem_ack,
        output imem_req, imem_addr, instr_valid, pc_out, pc_plus4, misalign_err
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_target, imem_ack,
        input  imem_req, imem_addr, instr_valid, pc_out, pc_plus4, misalign_err
    );

endinterface

// File: rtl/pc_fetch_sequencer_next_sel.sv
// Next-PC priority mux (jump > branch > sequential), +4 adder and target alignment.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned redirect traps to TRAP_VEC).
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
`ifdef MISALIGN_TRAP_EN
    ,
    parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'('hF0)
`endif
) (
    input  logic [ADDR_W-1:0] i_pc_plus4,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_target,
    output logic [ADDR_W-1:0] o_next_pc_c,
    output logic [ADDR_W-1:0] o_next_pc_plus4_c,
    output logic              o_misalign_c
);

    next_sel_t         w_sel;
    logic [ADDR_W-1:0] w_target;

    always_comb begin
        w_sel = SEL_SEQ;
        if (i_jump) begin
            w_sel = SEL_JMP;
        end else if (i_branch_taken) begin
            w_sel = SEL_BR;
        end
    end

    always_comb begin
        w_target = i_pc_plus4;
        case (w_sel)
            SEL_JMP: w_target = i_jump_target;
            SEL_BR:  w_target = i_branch_target;
            default: w_target = i_pc_plus4;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic w_is_redirect;

    assign w_is_redirect = (w_sel != SEL_SEQ);
    assign o_misalign_c  = w_is_redirect && ((w_target & ADDR_W'(ALIGN_MASK)) != '0);
    assign o_next_pc_c   = o_misalign_c ? TRAP_VEC : w_target;
`else
    // Low bits are dropped; the sequential path is already aligned so this only bites redirects.
    assign o_misalign_c  = 1'b0;
    assign o_next_pc_c   = w_target & ~ADDR_W'(ALIGN_MASK);
`endif

    assign o_next_pc_plus4_c = o_next_pc_c + ADDR_W'(PC_STEP);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC register and fetch FSM (BOOT/FETCH/EXEC/HOLD) with req/ack imem handshake.
// Optional feature macro: MISALIGN_TRAP_EN (adds TRAP_VEC and sticky misalign_err).
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'('h00)
`ifdef MISALIGN_TRAP_EN
    ,
    parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'('hF0)
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_fetch_sequencer_if.master bus
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_load;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_plus4;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_next_pc_plus4;
    logic              w_misalign;
    logic              r_imem_req;
    logic              r_instr_valid;
    logic              r_misalign_err;

    pc_next_sel #(
        .ADDR_W   (ADDR_W)
`ifdef MISALIGN_TRAP_EN
        ,
        .TRAP_VEC (TRAP_VEC)
`endif
    ) u_next_sel (
        .i_pc_plus4        (r_pc_plus4),
        .i_branch_taken    (bus.branch_taken),
        .i_branch_target   (bus.branch_target),
        .i_jump            (bus.jump),
        .i_jump_target     (bus.jump_target),
        .o_next_pc_c       (w_next_pc),
        .o_next_pc_plus4_c (w_next_pc_plus4),
        .o_misalign_c      (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Redirects only take effect on the cycle that leaves EXEC/HOLD (w_load).
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    w_state_next = EXEC;
                end
            end
            EXEC, HOLD: begin
                if (bus.stall) begin
                    w_state_next = HOLD;
                end else begin
                    w_load       = 1'b1;
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_pc_plus4     <= RESET_PC + ADDR_W'(PC_STEP);
            r_imem_req     <= 1'b0;
            r_instr_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            r_imem_req    <= (w_state_next == FETCH);
            r_instr_valid <= (w_state_next == EXEC);
            if (w_load) begin
                r_pc       <= w_next_pc;
                r_pc_plus4 <= w_next_pc_plus4;
            end
            if (w_load && w_misalign) begin
                r_misalign_err <= 1'b1;
            end
        end
    end

    assign bus.imem_req     = r_imem_req;
    assign bus.imem_addr    = r_pc;
    assign bus.instr_valid  = r_instr_valid;
    assign bus.pc_out       = r_pc;
    assign bus.pc_plus4     = r_pc_plus4;
    assign bus.misalign_err = r_misalign_err;

    a_addr_stable: assert property (@(posedge clk) disable iff (reset)
        (r_imem_req && !bus.imem_ack) |=> (r_imem_req && $stable(r_pc)));

    a_valid_pulse: assert property (@(posedge clk) disable iff (reset)
        r_instr_valid |=> !r_instr_valid);

endmodule
